// File: rtl/bictr_sweep_ctrl_pkg.sv
// Shared types and defaults for the up/down counter sweep sequencer.
package bictr_sweep_ctrl_pkg;

  localparam int unsigned STATE_W     = 2;
  localparam int unsigned DEF_WIDTH   = 4;
  localparam int unsigned DEF_SWEEP_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/bictr_sweep_ctrl_if.sv
// Control/status bus between the sweep sequencer and the up/down counter.
interface bictr_sweep_ctrl_if #(
  parameter int unsigned WIDTH = 4
);

  logic             ctr_load;
  logic             ctr_cen;
  logic             ctr_up_dn;
  logic [WIDTH-1:0] ctr_data;
  logic [WIDTH-1:0] ctr_count_to;
  logic             ctr_tercnt;

  modport master (
    output ctr_load, ctr_cen, ctr_up_dn, ctr_data, ctr_count_to,
    input  ctr_tercnt
  );

  modport slave (
    input  ctr_load, ctr_cen, ctr_up_dn, ctr_data, ctr_count_to,
    output ctr_tercnt
  );

endinterface

// File: rtl/bictr_sweep_ctrl.sv
// Sequencer running N back-to-back lo<->hi sweeps on an external up/down counter.
module bictr_sweep_ctrl
  import bictr_sweep_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SWEEP_W = DEF_SWEEP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [SWEEP_W-1:0] n_sweeps,
  input  logic               dir_init,
  output logic               busy,
  output logic               done,
  output logic               abort,
  output logic               err,
  output logic [SWEEP_W-1:0] sweep_cnt,
  output logic               dir,
  bictr_sweep_ctrl_if.master ctr
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [SWEEP_W-1:0]   n_q, n_d;
  logic [SWEEP_W-1:0]   sweep_cnt_q, sweep_cnt_d;
  logic                 dir_q, dir_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 abort_q, abort_d;
  logic                 err_q, err_d;
  logic                 load_n_q, load_n_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [WIDTH-1:0]     count_to_q, count_to_d;
  logic                 cen_c;

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      n_q         <= '0;
      sweep_cnt_q <= '0;
      dir_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
      load_n_q    <= 1'b1;
      data_q      <= '0;
      count_to_q  <= '0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      n_q         <= n_d;
      sweep_cnt_q <= sweep_cnt_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
      load_n_q    <= load_n_d;
      data_q      <= data_d;
      count_to_q  <= count_to_d;
    end
  end

  // Next state; stop outranks tercnt, and cen is gated in the same cycle so the count never overshoots
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    n_d         = n_q;
    sweep_cnt_d = sweep_cnt_q;
    dir_d       = dir_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    err_d       = 1'b0;
    load_n_d    = 1'b1;
    data_d      = data_q;
    count_to_d  = count_to_q;
    cen_c       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((lo < hi) && (n_sweeps != '0)) begin
            lo_d        = lo;
            hi_d        = hi;
            n_d         = n_sweeps;
            sweep_cnt_d = '0;
            dir_d       = dir_init;
            data_d      = dir_init ? lo : hi;
            count_to_d  = dir_init ? hi : lo;
            load_n_d    = 1'b0;
            busy_d      = 1'b1;
            state_d     = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        if (stop) begin
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        cen_c = ~ctr.ctr_tercnt & ~hold & ~stop;
        if (stop) begin
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end else if (ctr.ctr_tercnt) begin
          sweep_cnt_d = sweep_cnt_q + SWEEP_W'(1);
          if ((sweep_cnt_q + SWEEP_W'(1)) == n_q) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            // Turn around at the bound: the counter sits still this cycle, then heads back
            dir_d      = ~dir_q;
            count_to_d = dir_q ? lo_q : hi_q;
            busy_d     = 1'b1;
          end
        end else begin
          busy_d = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign abort     = abort_q;
  assign err       = err_q;
  assign sweep_cnt = sweep_cnt_q;
  assign dir       = dir_q;

  assign ctr.ctr_load     = load_n_q;
  assign ctr.ctr_cen      = cen_c;
  assign ctr.ctr_up_dn    = dir_q;
  assign ctr.ctr_data     = data_q;
  assign ctr.ctr_count_to = count_to_q;

endmodule

// File: tb/tb_bictr_sweep_ctrl.sv
// Directed bench for bictr_sweep_ctrl with a behavioural load/enable up/down counter beside it.
module tb_bictr_sweep_ctrl;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned SWEEP_W = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, stop, hold, dir_init;
  logic [WIDTH-1:0]   lo, hi;
  logic [SWEEP_W-1:0] n_sweeps;
  logic               busy, done, abort, err, dir;
  logic [SWEEP_W-1:0] sweep_cnt;
  logic [WIDTH-1:0]   count;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  bictr_sweep_ctrl_if #(.WIDTH(WIDTH)) ctr_if ();

  bictr_sweep_ctrl #(.WIDTH(WIDTH), .SWEEP_W(SWEEP_W)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start),
    .stop      (stop),
    .hold      (hold),
    .lo        (lo),
    .hi        (hi),
    .n_sweeps  (n_sweeps),
    .dir_init  (dir_init),
    .busy      (busy),
    .done      (done),
    .abort     (abort),
    .err       (err),
    .sweep_cnt (sweep_cnt),
    .dir       (dir),
    .ctr       (ctr_if)
  );

  always #5 clk = ~clk;

  // Counter: synchronous active-low load, count enable, combinational terminal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 count <= '0;
    else if (!ctr_if.ctr_load)  count <= ctr_if.ctr_data;
    else if (ctr_if.ctr_cen)    count <= ctr_if.ctr_up_dn ? count + 4'd1 : count - 4'd1;
  end
  assign ctr_if.ctr_tercnt = (count == ctr_if.ctr_count_to);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},     32'(busy), 32'd0);
    chk({tag, "_done"},     32'(done), 32'd0);
    chk({tag, "_abort"},    32'(abort), 32'd0);
    chk({tag, "_err"},      32'(err), 32'd0);
    chk({tag, "_sweep"},    32'(sweep_cnt), 32'd0);
    chk({tag, "_dir"},      32'(dir), 32'd1);
    chk({tag, "_load"},     32'(ctr_if.ctr_load), 32'd1);
    chk({tag, "_cen"},      32'(ctr_if.ctr_cen), 32'd0);
    chk({tag, "_data"},     32'(ctr_if.ctr_data), 32'd0);
    chk({tag, "_count_to"}, 32'(ctr_if.ctr_count_to), 32'd0);
  endtask

  // Counter value expected in each successive cycle
  task automatic check_run(input string tag);
    for (int k = 0; k < exp_q.size(); k++) begin
      chk($sformatf("%s[%0d]", tag, k), 32'(count), 32'(exp_q[k]));
      tick();
    end
  endtask

  initial begin
    int i;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
    lo = '0; hi = '0; n_sweeps = '0; dir_init = 1'b0;
    tick(); tick();
    chk_reset("rst");
    rst_n = 1'b1;
    tick();

    // Single upward sweep 2..5
    lo = 4'd2; hi = 4'd5; n_sweeps = 8'd1; dir_init = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk("t1_load", 32'(ctr_if.ctr_load), 32'd0);
    chk("t1_data", 32'(ctr_if.ctr_data), 32'd2);
    chk("t1_count_to", 32'(ctr_if.ctr_count_to), 32'd5);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    exp_q = '{2, 3, 4, 5};
    check_run("t1_cnt");
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy_done", 32'(busy), 32'd0);
    chk("t1_sweep", 32'(sweep_cnt), 32'd1);
    chk("t1_final", 32'(count), 32'd5);
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_hold_cnt", 32'(count), 32'd5);
    chk("t1_keep_to", 32'(ctr_if.ctr_count_to), 32'd5);

    // Four sweeps 1..3 starting downward
    lo = 4'd1; hi = 4'd3; n_sweeps = 8'd4; dir_init = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    chk("t2_data", 32'(ctr_if.ctr_data), 32'd3);
    chk("t2_count_to", 32'(ctr_if.ctr_count_to), 32'd1);
    chk("t2_dir", 32'(dir), 32'd0);
    tick();
    exp_q = '{3, 2, 1};
    check_run("t2_a");
    chk("t2_dir_turn", 32'(dir), 32'd1);
    chk("t2_to_turn", 32'(ctr_if.ctr_count_to), 32'd3);
    chk("t2_sweep1", 32'(sweep_cnt), 32'd1);
    exp_q = '{1, 2, 3, 3, 2, 1, 1, 2, 3};
    check_run("t2_b");
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_sweep", 32'(sweep_cnt), 32'd4);
    chk("t2_dir_end", 32'(dir), 32'd1);
    chk("t2_final", 32'(count), 32'd3);
    tick();

    // Two full-range sweeps with hold high for three cycles at count 4
    lo = 4'd0; hi = 4'd15; n_sweeps = 8'd2; dir_init = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    i = 0;
    while (!done && i < 200) begin
      hold = (i >= 4 && i < 7);
      #1;
      if (i == 5) chk("t3_cen_hold", 32'(ctr_if.ctr_cen), 32'd0);
      if (i == 7) chk("t3_frozen", 32'(count), 32'd4);
      if (i == 8) chk("t3_resume", 32'(count), 32'd5);
      i++;
      tick();
    end
    hold = 1'b0;
    chk("t3_run_cycles", 32'(i), 32'd35);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_sweep", 32'(sweep_cnt), 32'd2);
    chk("t3_final", 32'(count), 32'd0);
    chk("t3_dir", 32'(dir), 32'd0);
    tick();

    // Stop at count 4 of a 2..9 sweep
    lo = 4'd2; hi = 4'd9; n_sweeps = 8'd2; dir_init = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("t4_at4", 32'(count), 32'd4);
    stop = 1'b1;
    #1;
    chk("t4_cen_stop", 32'(ctr_if.ctr_cen), 32'd0);
    tick(); stop = 1'b0;
    chk("t4_abort", 32'(abort), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_sweep", 32'(sweep_cnt), 32'd0);
    chk("t4_cnt", 32'(count), 32'd4);
    tick();
    chk("t4_abort_pulse", 32'(abort), 32'd0);
    chk("t4_cnt_still", 32'(count), 32'd4);

    // Rejected starts: lo==hi, n==0, lo>hi
    lo = 4'd7; hi = 4'd7; n_sweeps = 8'd3; start = 1'b1;
    tick(); start = 1'b0;
    chk("t5_err_eq", 32'(err), 32'd1);
    chk("t5_busy_eq", 32'(busy), 32'd0);
    chk("t5_load_eq", 32'(ctr_if.ctr_load), 32'd1);
    tick();
    chk("t5_err_pulse", 32'(err), 32'd0);
    lo = 4'd1; hi = 4'd5; n_sweeps = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("t5_err_n0", 32'(err), 32'd1);
    lo = 4'd9; hi = 4'd3; n_sweeps = 8'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk("t5_err_gt", 32'(err), 32'd1);
    chk("t5_busy_gt", 32'(busy), 32'd0);
    tick();
    chk("t5_cnt", 32'(count), 32'd4);
    chk("t5_count_to", 32'(ctr_if.ctr_count_to), 32'd9);

    // Stop while idle is ignored
    stop = 1'b1;
    tick(); stop = 1'b0;
    chk("t5_idle_abort", 32'(abort), 32'd0);
    chk("t5_idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-run, then a clean restart
    lo = 4'd3; hi = 4'd12; n_sweeps = 8'd1; dir_init = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("t6_pre", 32'(count), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("t6_rst");
    chk("t6_cnt", 32'(count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    lo = 4'd2; hi = 4'd5; n_sweeps = 8'd1; dir_init = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    exp_q = '{2, 3, 4, 5};
    check_run("t6_cnt");
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_sweep", 32'(sweep_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
